// File: rtl/alu_cmd_issuer.sv
// Command issuer: buffers ALU commands in a FIFO, drives them one at a time to an external
// combinational ALU and holds each result until it is consumed. Optional macro: ALU_ISSUER_DIVZERO_EN.
module alu_cmd_issuer #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_opcode,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [3:0]  alu_opcode,
   input  logic [15:0] alu_out,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic [3:0]  rsp_opcode,
   output logic        rsp_err,
   output logic        busy
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state, state_next;
   logic [19:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push, pop, capture, fifo_empty;
   logic [19:0]      head;
   logic [15:0]      capture_data;

   // cmd_ready depends only on the registered count, never on the FSM's pop decision.
   assign fifo_empty = (count == '0);
   assign cmd_ready  = (count != FULL_COUNT);
   assign push       = cmd_valid && cmd_ready;
   assign head       = fifo_mem[rd_ptr];
   assign busy       = (state != IDLE) || !fifo_empty;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {cmd_opcode, cmd_a, cmd_b};
      end
   end

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               state_next = EXEC;
            end
         end
         EXEC: begin
            capture    = 1'b1;
            state_next = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  state_next = EXEC;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ALU operands only change on a pop, so they hold their last value outside EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_opcode <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
      end else if (pop) begin
         {alu_opcode, alu_a, alu_b} <= head;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_opcode <= '0;
      end else if (capture) begin
         rsp_valid  <= 1'b1;
         rsp_data   <= capture_data;
         rsp_opcode <= alu_opcode;
      end else if ((state == RESP) && rsp_ready) begin
         rsp_valid  <= 1'b0;
      end
   end

`ifdef ALU_ISSUER_DIVZERO_EN
   // A divide by zero still spends its EXEC cycle; only the captured result is replaced.
   logic div_zero;
   assign div_zero     = (alu_opcode == 4'b0011) && (alu_b == 8'h00);
   assign capture_data = div_zero ? 16'h0000 : alu_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       rsp_err <= 1'b0;
      else if (capture) rsp_err <= div_zero;
   end
`else
   assign capture_data = alu_out;
   assign rsp_err      = 1'b0;
`endif

endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, command FIFO depth; power of two, 2..16.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted when high with cmd_valid at a rising edge.
REQ-007 cmd_opcode  input  4  ALU opcode; bit 3 = 0 arithmetic group, bit 3 = 1 logic group.
REQ-008 cmd_a, cmd_b  input  8 each  operands.
REQ-009 alu_a, alu_b  output  8 each  registered operands driven to the combinational ALU.
REQ-010 alu_opcode  output  4  registered opcode driven to the ALU.
REQ-011 alu_out  input  16  ALU result, combinational from alu_a/alu_b/alu_opcode.
REQ-012 rsp_valid  output  1  result available.
REQ-013 rsp_ready  input  1  result consumed when high with rsp_valid at a rising edge.
REQ-014 rsp_data  output  16  captured result.
REQ-015 rsp_opcode  output  4  opcode that produced rsp_data.
REQ-016 rsp_err  output  1  divide-by-zero flag (see Configuration).
REQ-017 busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-018 The FIFO stores {opcode, a, b} (20 bits); cmd_ready = (count != FIFO_DEPTH), driven from registered count only.
REQ-019 Push and pop in the same cycle leave count unchanged; there is no push when full and no pop when empty.
REQ-020 The FIFO pointers wrap modulo FIFO_DEPTH; commands issue strictly in acceptance order.
REQ-021 FSM states: IDLE, EXEC, RESP.
REQ-022 IDLE: if the FIFO is non-empty, pop the head into alu_a/alu_b/alu_opcode and go to EXEC; otherwise stay.
REQ-023 EXEC lasts exactly one cycle with ALU inputs stable; at its closing edge, capture alu_out into rsp_data and alu_opcode into rsp_opcode, set rsp_valid, and go to RESP.
REQ-024 RESP: rsp_valid, rsp_data, rsp_opcode and rsp_err hold stable until rsp_ready.
REQ-025 On the RESP handshake edge, clear rsp_valid unless a new result is captured. If the FIFO is non-empty, pop the next command and go to EXEC; otherwise go to IDLE.
REQ-026 Latency: a command accepted at edge N into an empty FIFO with the FSM in IDLE is popped at N+1, and rsp_valid rises after edge N+2.
REQ-027 Sustained throughput with rsp_ready held high: one result per 2 cycles.
REQ-028 Total in-flight capacity is FIFO_DEPTH + 1 (FIFO plus one issued command).
REQ-029 alu_* outputs keep their last value when the FSM is not in EXEC.

Reset
REQ-030 rst_n low asynchronously forces: FSM to IDLE, FIFO empty, count 0, and alu_a, alu_b, alu_opcode, rsp_valid, rsp_data, rsp_opcode, rsp_err and busy all 0.
REQ-031 Reset mid-operation discards every queued and in-flight command; no response for them appears after reset release.
REQ-032 cmd_ready reads 1 during reset and after release.

Configuration
REQ-033 Macro ALU_ISSUER_DIVZERO_EN, defined: a command with opcode 4'b0011 and b == 0 still runs through EXEC, but the capture forces rsp_data = 16'h0000 and rsp_err = 1. All other commands capture rsp_err = 0.
REQ-034 Macro ALU_ISSUER_DIVZERO_EN, undefined: rsp_err is tied to 0 and rsp_data = alu_out unconditionally.

Verification
REQ-035 Single add: opcode 4'b0000, a = 8'h05, b = 8'h03 accepted at edge N -> rsp_valid after N+2, rsp_data = 16'h0008, rsp_opcode = 4'b0000.
REQ-036 Fill: rsp_ready = 0, offer 6 commands (opcodes 0000..0101 in that order) -> exactly 5 accepted, then cmd_ready = 0. Raise rsp_ready -> 5 responses in order, then the 6th accepted.
REQ-037 Backpressure: hold rsp_ready = 0 for 10 cycles with a result pending (opcode 4'b1000, a = 8'hF0, b = 8'h3C) -> rsp_data = 16'h0030 stable for all 10 cycles, and alu_* unchanged.
REQ-038 Divide by zero: opcode 4'b0011, a = 8'h10, b = 8'h00 -> with the macro, rsp_err = 1 and rsp_data = 16'h0000; without it, rsp_err = 0.
REQ-039 Reset in EXEC with 3 commands queued -> all outputs 0 immediately, cmd_ready = 1, and no rsp_valid for 20 cycles after release.
REQ-040 Streaming: 8 back-to-back commands with rsp_ready = 1 -> responses on every second cycle, in order, and the FIFO pointer wraps with no loss or duplication.
